// File: rtl/alu_result_display.sv
// Captures the 16-bit ALU result and flags on a load strobe. Shows them as four hex digits on a
// multiplexed active-low 7-segment display, committing new values only at scan-frame boundaries.
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] res_in,
    input  logic        cout_in,
    input  logic        zero_in,
    output logic        load_ack,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shown_q, shown_d;
    logic             cout_shown_q, cout_shown_d;
    logic             zero_shown_q, zero_shown_d;
    logic [15:0]      pend_res_q, pend_res_d;
    logic             pend_cout_q, pend_cout_d;
    logic             pend_zero_q, pend_zero_d;
    logic             pending_q, pending_d;
    logic             load_ack_q, load_ack_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             wrap;
    logic             frame_end;
    logic             commit;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan timing and commit decision
    always_comb begin
        wrap      = (cnt_q == CntMax);
        frame_end = wrap && (idx_q == 2'd3);
        commit    = frame_end && (pending_q || load);

        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end

    // Capture and commit; a load on the boundary cycle bypasses the pending register
    always_comb begin
        pend_res_d   = pend_res_q;
        pend_cout_d  = pend_cout_q;
        pend_zero_d  = pend_zero_q;
        pending_d    = pending_q;
        shown_d      = shown_q;
        cout_shown_d = cout_shown_q;
        zero_shown_d = zero_shown_q;
        load_ack_d   = commit;

        if (load) begin
            pend_res_d  = res_in;
            pend_cout_d = cout_in;
            pend_zero_d = zero_in;
        end

        if (commit) begin
            pending_d    = 1'b0;
            shown_d      = load ? res_in  : pend_res_q;
            cout_shown_d = load ? cout_in : pend_cout_q;
            zero_shown_d = load ? zero_in : pend_zero_q;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Display drive from the current digit index and the currently shown value
    always_comb begin
        nibble = shown_q[{idx_q, 2'b00} +: 4];
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = hex7(nibble);
        case (idx_q)
            2'd3:    dp_d = ~cout_shown_q;
            2'd0:    dp_d = ~zero_shown_q;
            default: dp_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            cout_shown_q <= 1'b0;
            zero_shown_q <= 1'b0;
            pend_res_q   <= '0;
            pend_cout_q  <= 1'b0;
            pend_zero_q  <= 1'b0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            cout_shown_q <= cout_shown_d;
            zero_shown_q <= zero_shown_d;
            pend_res_q   <= pend_res_d;
            pend_cout_q  <= pend_cout_d;
            pend_zero_q  <= pend_zero_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign load_ack = load_ack_q;
    assign pending  = pending_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule
